// File: rtl/mealy_seq_detector_if.sv
// Sample/strobe bundle between a serial bit source and the sequence detector.
// The master drives the sample stream; the slave (detector) returns strobes and status.
interface mealy_seq_detector_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             x_in;
    logic             clear;
    logic             y_out;
    logic             y_reg;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    modport master (
        output en, x_in, clear,
        input  y_out, y_reg, armed, match_count
    );

    modport slave (
        input  en, x_in, clear,
        output y_out, y_reg, armed, match_count
    );
endinterface

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy serial pattern detector with overlap control, a registered strobe
// copy, synchronous clear and a saturating match counter.
module mealy_seq_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    mealy_seq_detector_if.slave bus
);
    localparam int HW = PAT_LEN - 1;
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(HW);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        ARMED   = 2'd2
    } fill_state_t;

    fill_state_t      state;
    logic [HW-1:0]    hist;
    logic [FW-1:0]    fill;
    logic             y_reg_q;
    logic [CNT_W-1:0] count_q;

    logic             match;
    logic [HW-1:0]    hist_shift;
    logic [FW-1:0]    fill_inc;

    // A one-bit history simply becomes the newest sample; wider ones shift left.
    generate
        if (HW == 1) begin : g_hist_one
            assign hist_shift = bus.x_in;
        end else begin : g_hist_wide
            assign hist_shift = {hist[HW-2:0], bus.x_in};
        end
    endgenerate

    assign fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
    assign match    = bus.en & ~bus.clear & (state == ARMED)
                      & ({hist, bus.x_in} == PATTERN);

    function automatic fill_state_t state_of(input logic [FW-1:0] f);
        if (f == '0)
            return EMPTY;
        else if (f == FILL_MAX)
            return ARMED;
        else
            return PARTIAL;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= EMPTY;
            hist    <= '0;
            fill    <= '0;
            y_reg_q <= 1'b0;
            count_q <= '0;
        end else if (bus.clear) begin
            state   <= EMPTY;
            hist    <= '0;
            fill    <= '0;
            y_reg_q <= 1'b0;
            count_q <= '0;
        end else begin
            y_reg_q <= match;
            if (match && count_q != '1)
                count_q <= count_q + 1'b1;
            if (bus.en) begin
                hist <= hist_shift;
                // Non-overlapping mode restarts collection from scratch after every hit.
                if (match && !OVERLAP) begin
                    fill  <= '0;
                    state <= EMPTY;
                end else begin
                    fill  <= fill_inc;
                    state <= state_of(fill_inc);
                end
            end
        end
    end

    assign bus.y_out       = match;
    assign bus.y_reg       = y_reg_q;
    assign bus.armed       = (state == ARMED);
    assign bus.match_count = count_q;
endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench for mealy_seq_detector: three instances cover overlap, non-overlap
// and a 2-bit pattern with a 2-bit saturating counter.
module tb_mealy_seq_detector;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        logic       en;
        logic       x;
        logic       clr;
        logic       exp_y;
        logic       exp_armed;
        logic       exp_yreg;
        logic [7:0] exp_cnt;
    } row_t;

    typedef struct {
        logic       y_out;
        logic       armed;
        logic       y_reg;
        logic [7:0] cnt;
    } obs_t;

    row_t exp_q[$];

    mealy_seq_detector_if #(.CNT_W(8)) ov_if ();
    mealy_seq_detector_if #(.CNT_W(8)) nov_if ();
    mealy_seq_detector_if #(.CNT_W(2)) sat_if ();

    mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .clock (clock),
        .reset (reset),
        .bus   (ov_if.slave)
    );

    mealy_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
        .clock (clock),
        .reset (reset),
        .bus   (nov_if.slave)
    );

    mealy_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (sat_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic row_t mk(input logic en, input logic x, input logic clr,
                                input logic y, input logic arm, input logic yreg,
                                input logic [7:0] cnt);
        row_t r;
        r.en = en; r.x = x; r.clr = clr;
        r.exp_y = y; r.exp_armed = arm; r.exp_yreg = yreg; r.exp_cnt = cnt;
        return r;
    endfunction

    function automatic obs_t observe(input int which);
        obs_t o;
        case (which)
            0: begin o.y_out = ov_if.y_out;  o.armed = ov_if.armed;  o.y_reg = ov_if.y_reg;  o.cnt = ov_if.match_count;  end
            1: begin o.y_out = nov_if.y_out; o.armed = nov_if.armed; o.y_reg = nov_if.y_reg; o.cnt = nov_if.match_count; end
            default: begin o.y_out = sat_if.y_out; o.armed = sat_if.armed; o.y_reg = sat_if.y_reg; o.cnt = {6'b0, sat_if.match_count}; end
        endcase
        return o;
    endfunction

    task automatic drive(input int which, input logic en, input logic x, input logic clr);
        case (which)
            0: begin ov_if.en = en;  ov_if.x_in = x;  ov_if.clear = clr;  end
            1: begin nov_if.en = en; nov_if.x_in = x; nov_if.clear = clr; end
            default: begin sat_if.en = en; sat_if.x_in = x; sat_if.clear = clr; end
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        idle_all();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Pushes each row's expectation as the row is driven, then pops it for comparison.
    task automatic run_rows(input int which, input row_t rows[$], output row_t done[$]);
        done.delete();
        foreach (rows[i]) begin
            @(negedge clock);
            drive(which, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            done.push_back(exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        obs_t o;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b1, 1'b0);
        #3;
        for (int k = 0; k < 3; k++) begin
            o = observe(k);
            checks++;
            if (o.y_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_out dut%0d: got %b expected 0", k, o.y_out); end
            checks++;
            if (o.armed !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed dut%0d: got %b expected 0", k, o.armed); end
            checks++;
            if (o.y_reg !== 1'b0) begin errors++; $display("[TB] FAIL reset_y_reg dut%0d: got %b expected 0", k, o.y_reg); end
            checks++;
            if (o.cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_count dut%0d: got %0d expected 0", k, o.cnt); end
        end
        idle_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_overlap();
        row_t rows[$];
        row_t e;
        obs_t o;
        int   n;
        apply_reset();
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 1,1,1,8'd1));
        rows.push_back(mk(1,1,0, 0,1,0,8'd1));
        rows.push_back(mk(1,0,0, 0,1,0,8'd1));
        rows.push_back(mk(1,1,0, 1,1,1,8'd2));
        rows.push_back(mk(0,0,0, 0,1,0,8'd2));
        n = 0;
        foreach (rows[i]) begin
            @(negedge clock);
            drive(0, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            e = exp_q.pop_front();
            o = observe(0);
            n++;
            checks++;
            if (o.y_out !== e.exp_y) begin errors++; $display("[TB] FAIL overlap_y_out step %0d: got %b expected %b", n, o.y_out, e.exp_y); end
            checks++;
            if (o.armed !== e.exp_armed) begin errors++; $display("[TB] FAIL overlap_armed step %0d: got %b expected %b", n, o.armed, e.exp_armed); end
            @(posedge clock);
            #1;
            o = observe(0);
            checks++;
            if (o.y_reg !== e.exp_yreg) begin errors++; $display("[TB] FAIL overlap_y_reg step %0d: got %b expected %b", n, o.y_reg, e.exp_yreg); end
            checks++;
            if (o.cnt !== e.exp_cnt) begin errors++; $display("[TB] FAIL overlap_count step %0d: got %0d expected %0d", n, o.cnt, e.exp_cnt); end
        end
    endtask

    task automatic test_non_overlap();
        row_t rows[$];
        row_t e;
        obs_t o;
        int   n;
        apply_reset();
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 1,1,1,8'd1));
        rows.push_back(mk(1,1,0, 0,0,0,8'd1));
        rows.push_back(mk(1,0,0, 0,0,0,8'd1));
        rows.push_back(mk(1,1,0, 0,0,0,8'd1));
        rows.push_back(mk(0,0,0, 0,1,0,8'd1));
        n = 0;
        foreach (rows[i]) begin
            @(negedge clock);
            drive(1, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            e = exp_q.pop_front();
            o = observe(1);
            n++;
            checks++;
            if (o.y_out !== e.exp_y) begin errors++; $display("[TB] FAIL nonoverlap_y_out step %0d: got %b expected %b", n, o.y_out, e.exp_y); end
            checks++;
            if (o.armed !== e.exp_armed) begin errors++; $display("[TB] FAIL nonoverlap_armed step %0d: got %b expected %b", n, o.armed, e.exp_armed); end
            @(posedge clock);
            #1;
            o = observe(1);
            checks++;
            if (o.y_reg !== e.exp_yreg) begin errors++; $display("[TB] FAIL nonoverlap_y_reg step %0d: got %b expected %b", n, o.y_reg, e.exp_yreg); end
            checks++;
            if (o.cnt !== e.exp_cnt) begin errors++; $display("[TB] FAIL nonoverlap_count step %0d: got %0d expected %0d", n, o.cnt, e.exp_cnt); end
        end
    endtask

    task automatic test_en_gating();
        row_t rows[$];
        row_t e;
        obs_t o;
        int   n;
        apply_reset();
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        for (int g = 0; g < 3; g++) rows.push_back(mk(0,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 1,1,1,8'd1));
        rows.push_back(mk(0,1,0, 0,1,0,8'd1));
        n = 0;
        foreach (rows[i]) begin
            @(negedge clock);
            drive(0, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            e = exp_q.pop_front();
            o = observe(0);
            n++;
            checks++;
            if (o.y_out !== e.exp_y) begin errors++; $display("[TB] FAIL engate_y_out step %0d: got %b expected %b", n, o.y_out, e.exp_y); end
            checks++;
            if (o.armed !== e.exp_armed) begin errors++; $display("[TB] FAIL engate_armed step %0d: got %b expected %b", n, o.armed, e.exp_armed); end
            @(posedge clock);
            #1;
            o = observe(0);
            checks++;
            if (o.y_reg !== e.exp_yreg) begin errors++; $display("[TB] FAIL engate_y_reg step %0d: got %b expected %b", n, o.y_reg, e.exp_yreg); end
            checks++;
            if (o.cnt !== e.exp_cnt) begin errors++; $display("[TB] FAIL engate_count step %0d: got %0d expected %0d", n, o.cnt, e.exp_cnt); end
        end
    endtask

    task automatic test_saturation();
        row_t rows[$];
        row_t e;
        obs_t o;
        int   n;
        apply_reset();
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 1,1,1,8'd1));
        rows.push_back(mk(1,1,0, 1,1,1,8'd2));
        rows.push_back(mk(1,1,0, 1,1,1,8'd3));
        rows.push_back(mk(1,1,0, 1,1,1,8'd3));
        rows.push_back(mk(1,1,0, 1,1,1,8'd3));
        rows.push_back(mk(1,1,0, 1,1,1,8'd3));
        rows.push_back(mk(0,1,0, 0,1,0,8'd3));
        n = 0;
        foreach (rows[i]) begin
            @(negedge clock);
            drive(2, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            e = exp_q.pop_front();
            o = observe(2);
            n++;
            checks++;
            if (o.y_out !== e.exp_y) begin errors++; $display("[TB] FAIL saturate_y_out step %0d: got %b expected %b", n, o.y_out, e.exp_y); end
            checks++;
            if (o.armed !== e.exp_armed) begin errors++; $display("[TB] FAIL saturate_armed step %0d: got %b expected %b", n, o.armed, e.exp_armed); end
            @(posedge clock);
            #1;
            o = observe(2);
            checks++;
            if (o.y_reg !== e.exp_yreg) begin errors++; $display("[TB] FAIL saturate_y_reg step %0d: got %b expected %b", n, o.y_reg, e.exp_yreg); end
            checks++;
            if (o.cnt !== e.exp_cnt) begin errors++; $display("[TB] FAIL saturate_count step %0d: got %0d expected %0d", n, o.cnt, e.exp_cnt); end
        end
    endtask

    task automatic test_reset_mid_sequence();
        row_t rows[$];
        row_t e;
        obs_t o;
        int   n;
        apply_reset();
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 1,1,1,8'd1));
        n = 0;
        foreach (rows[i]) begin
            @(negedge clock);
            drive(0, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            e = exp_q.pop_front();
            o = observe(0);
            n++;
            checks++;
            if (o.y_out !== e.exp_y) begin errors++; $display("[TB] FAIL midreset_y_out step %0d: got %b expected %b", n, o.y_out, e.exp_y); end
            checks++;
            if (o.armed !== e.exp_armed) begin errors++; $display("[TB] FAIL midreset_armed step %0d: got %b expected %b", n, o.armed, e.exp_armed); end
            @(posedge clock);
            #1;
            o = observe(0);
            checks++;
            if (o.y_reg !== e.exp_yreg) begin errors++; $display("[TB] FAIL midreset_y_reg step %0d: got %b expected %b", n, o.y_reg, e.exp_yreg); end
            checks++;
            if (o.cnt !== e.exp_cnt) begin errors++; $display("[TB] FAIL midreset_count step %0d: got %0d expected %0d", n, o.cnt, e.exp_cnt); end
            // Asynchronous reset pulse between edges once 1,1,0 has armed the detector.
            if (n == 3) begin
                drive(0, 1'b0, 1'b0, 1'b0);
                reset = 1'b0;
                #1;
                o = observe(0);
                checks++;
                if (o.armed !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pulse_armed: got %b expected 0", o.armed); end
                checks++;
                if (o.cnt !== 8'd0) begin errors++; $display("[TB] FAIL midreset_pulse_count: got %0d expected 0", o.cnt); end
                #1;
                reset = 1'b1;
            end
        end
    endtask

    task automatic test_clear_priority();
        row_t rows[$];
        row_t e;
        obs_t o;
        int   n;
        apply_reset();
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(1,0,0, 0,0,0,8'd0));
        rows.push_back(mk(1,1,0, 1,1,1,8'd1));
        rows.push_back(mk(1,1,0, 0,1,0,8'd1));
        rows.push_back(mk(1,0,0, 0,1,0,8'd1));
        rows.push_back(mk(1,1,1, 0,1,0,8'd0));
        rows.push_back(mk(1,1,0, 0,0,0,8'd0));
        rows.push_back(mk(0,0,0, 0,0,0,8'd0));
        n = 0;
        foreach (rows[i]) begin
            @(negedge clock);
            drive(0, rows[i].en, rows[i].x, rows[i].clr);
            exp_q.push_back(rows[i]);
            #2;
            e = exp_q.pop_front();
            o = observe(0);
            n++;
            checks++;
            if (o.y_out !== e.exp_y) begin errors++; $display("[TB] FAIL clear_y_out step %0d: got %b expected %b", n, o.y_out, e.exp_y); end
            checks++;
            if (o.armed !== e.exp_armed) begin errors++; $display("[TB] FAIL clear_armed step %0d: got %b expected %b", n, o.armed, e.exp_armed); end
            @(posedge clock);
            #1;
            o = observe(0);
            checks++;
            if (o.y_reg !== e.exp_yreg) begin errors++; $display("[TB] FAIL clear_y_reg step %0d: got %b expected %b", n, o.y_reg, e.exp_yreg); end
            checks++;
            if (o.cnt !== e.exp_cnt) begin errors++; $display("[TB] FAIL clear_count step %0d: got %0d expected %0d", n, o.cnt, e.exp_cnt); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_all();
        test_reset();
        test_overlap();
        test_non_overlap();
        test_en_gating();
        test_saturation();
        test_reset_mid_sequence();
        test_clear_priority();
        idle_all();
        repeat (2) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
